// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider (DIV/DIVU), one quotient bit per clock
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] orig_q, orig_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;

    logic             a_neg, b_neg, div0;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, diff;

    assign a_neg   = is_signed & dividend[WIDTH-1];
    assign b_neg   = is_signed & divisor[WIDTH-1];
    assign a_mag   = a_neg ? -dividend : dividend;
    assign b_mag   = b_neg ? -divisor : divisor;
    assign shifted = {rem_q, shreg_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign div0    = dvs_q == '0;

    assign busy        = (state_q == RUN) || (state_q == FIX);
    assign done        = state_q == DONE;
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

    // Next-state: operand capture, one restoring step per RUN cycle, sign fix-up and result load
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        shreg_d = shreg_q;
        dvs_d   = dvs_q;
        orig_d  = orig_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        case (state_q)
            RUN: begin
                rem_d   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                shreg_d = {shreg_q[WIDTH-2:0], ~diff[WIDTH]};
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? FIX : RUN;
            end
            FIX: begin
                dbz_d   = div0;
                quot_d  = div0 ? '1 : (qneg_q ? -shreg_q : shreg_q);
                remo_d  = div0 ? orig_q : (rneg_q ? -rem_q : rem_q);
                state_d = DONE;
            end
            default: begin
                state_d = start ? RUN : IDLE;
                if (start) begin
                    rem_d   = '0;
                    shreg_d = a_mag;
                    dvs_d   = b_mag;
                    orig_d  = dividend;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    cnt_d   = CNT_W'(WIDTH);
                end
            end
        endcase
    end

    // State and datapath registers; reset aborts any division in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            shreg_q <= '0;
            dvs_q   <= '0;
            orig_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            shreg_q <= shreg_d;
            dvs_q   <= dvs_d;
            orig_q  <= orig_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against an arithmetic model
module tb_seq_divider;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    // Reference: 64-bit arithmetic truncating division; remainder sign follows dividend
    task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        longint la, lb;
        la = s ? longint'($signed(a)) : longint'(a);
        lb = s ? longint'($signed(b)) : longint'(b);
        if (b == '0) begin
            q = '1; r = a; dz = 1'b1;
        end else begin
            q = W'(la / lb); r = W'(la % lb); dz = 1'b0;
        end
    endtask

    // Called at a negedge; start is seen by the following posedge, returns at the next negedge
    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        is_signed = s; dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat counts posedges from the sampling edge inclusive until done is seen
    task automatic wait_done(output int lat, output int bc);
        lat = 1; bc = 0;
        while (!done && lat < 60) begin
            bc += int'(busy);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (quotient !== '0) begin fails++; $display("FAIL reset_q got %h want 0", quotient); end
        tests++; if (remainder !== '0) begin fails++; $display("FAIL reset_r got %h want 0", remainder); end
        tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dz got %b want 0", div_by_zero); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic         vs[12] = '{0, 1, 1, 0, 0, 1, 0, 1, 1, 0, 1, 0};
        logic [W-1:0] va[12] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'd5, 32'd10, 32'h80000000,
                                 32'hFFFFFFFF, 32'd0, 32'hFFFFFFF0, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFFE};
        logic [W-1:0] vb[12] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd0, 32'd3, 32'hFFFFFFFF,
                                 32'd1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [W-1:0] eq[12] = '{32'd14, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd3, 32'h80000000,
                                 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd3, 32'd0};
        logic [W-1:0] er[12] = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'd5, 32'd1, 32'd0,
                                 32'd0, 32'd0, 32'hFFFFFFF0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
        logic         ez[12] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        int lat, bc;
        for (int i = 0; i < 12; i++) begin
            issue(vs[i], va[i], vb[i]);
            wait_done(lat, bc);
            tests++; if (lat !== 34) begin fails++; $display("FAIL dir%0d_latency got %0d want 34", i, lat); end
            tests++; if (bc !== 33) begin fails++; $display("FAIL dir%0d_busy_cycles got %0d want 33", i, bc); end
            tests++; if (quotient !== eq[i]) begin fails++; $display("FAIL dir%0d_q got %h want %h", i, quotient, eq[i]); end
            tests++; if (remainder !== er[i]) begin fails++; $display("FAIL dir%0d_r got %h want %h", i, remainder, er[i]); end
            tests++; if (div_by_zero !== ez[i]) begin fails++; $display("FAIL dir%0d_dz got %b want %b", i, div_by_zero, ez[i]); end
            @(negedge clk);
            tests++; if (done !== 1'b0) begin fails++; $display("FAIL dir%0d_done_pulse got %b want 0", i, done); end
        end
    endtask

    task automatic test_random;
        logic         s;
        logic [W-1:0] a, b, q, r;
        logic         dz;
        int lat, bc;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = $urandom_range(1, 15);
                2: b = -W'($urandom_range(1, 15));
                3: b = $urandom >> $urandom_range(0, 31);
                default: b = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom_range(1, 3));
            endcase
            model(s, a, b, q, r, dz);
            issue(s, a, b);
            wait_done(lat, bc);
            tests++; if (lat !== 34) begin fails++; $display("FAIL rnd%0d_latency got %0d want 34", i, lat); end
            tests++; if (quotient !== q || remainder !== r || div_by_zero !== dz) begin
                fails++;
                $display("FAIL rnd%0d s=%b %h/%h got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                         i, s, a, b, quotient, remainder, div_by_zero, q, r, dz);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start;
        int lat, bc;
        issue(1'b0, 32'd1000, 32'd7);
        repeat (5) @(negedge clk);
        is_signed = 1'b1; dividend = 32'd55; divisor = 32'd3; start = 1'b1;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ign_busy got %b want 1", busy); end
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        tests++; if (lat !== 28) begin fails++; $display("FAIL ign_latency got %0d want 28", lat); end
        tests++; if (quotient !== 32'd142) begin fails++; $display("FAIL ign_q got %h want %h", quotient, 32'd142); end
        tests++; if (remainder !== 32'd6) begin fails++; $display("FAIL ign_r got %h want %h", remainder, 32'd6); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        issue(1'b0, 32'd100, 32'd7);
        wait_done(lat, bc);
        tests++; if (quotient !== 32'd14) begin fails++; $display("FAIL b2b1_q got %h want %h", quotient, 32'd14); end
        issue(1'b1, 32'hFFFFFFF9, 32'd2);
        wait_done(lat, bc);
        tests++; if (lat !== 34) begin fails++; $display("FAIL b2b2_latency got %0d want 34", lat); end
        tests++; if (quotient !== 32'hFFFFFFFD) begin fails++; $display("FAIL b2b2_q got %h want FFFFFFFD", quotient); end
        tests++; if (remainder !== 32'hFFFFFFFF) begin fails++; $display("FAIL b2b2_r got %h want FFFFFFFF", remainder); end
        dividend = 32'd9; divisor = 32'd4;
        repeat (3) @(negedge clk);
        tests++; if (quotient !== 32'hFFFFFFFD || remainder !== 32'hFFFFFFFF || done !== 1'b0) begin
            fails++; $display("FAIL hold got q=%h r=%h done=%b want q=FFFFFFFD r=FFFFFFFF done=0", quotient, remainder, done);
        end
    endtask

    task automatic test_reset_mid;
        int lat, bc, seen;
        issue(1'b0, 32'd12345, 32'd11);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b want 0", busy); end
        tests++; if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            fails++; $display("FAIL rmid_outputs got q=%h r=%h dz=%b want 0", quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            seen += int'(done);
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL rmid_no_done got %0d pulses want 0", seen); end
        issue(1'b0, 32'd12345, 32'd11);
        wait_done(lat, bc);
        tests++; if (lat !== 34) begin fails++; $display("FAIL rmid_latency got %0d want 34", lat); end
        tests++; if (quotient !== 32'd1122 || remainder !== 32'd3) begin
            fails++; $display("FAIL rmid_result got q=%h r=%h want q=%h r=%h", quotient, remainder, 32'd1122, 32'd3);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
